inst_sram_resp: RTL
===================

Name: inst_sram_resp

Overview:
- Responder (memory side) of the SRAM-style instruction-fetch interface driven by the fetch stage: en/we/addr/wdata in, rdata out one cycle later.
- Holds a word-organised instruction store mapped at a base physical address.
- Returns LoongArch NOP for out-of-range fetches and flags address errors.
- Includes a backdoor load port for test preload, and read/write access counters.

Parameters:
- BASE_ADDR, 32'h1c000000, byte address of word 0 (reset fetch target).
- DEPTH_LOG2, 12, log2 of store depth in 32-bit words (default 4096 words = 16 KiB).
- NOP_INST, 32'h03400000, data returned for out-of-range reads (andi r0,r0,0).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- sram_en  in  1  access request this cycle.
- sram_we  in  4  byte write enables; bit i writes wdata[8i+7:8i]; 0 means read.
- sram_addr  in  32  byte address.
- sram_wdata  in  32  write data.
- sram_rdata  out  32  read data, registered, valid the cycle after a read request.
- load_valid  in  1  backdoor preload request.
- load_ready  out  1  backdoor accepted this cycle (combinational).
- load_index  in  DEPTH_LOG2  word index for preload.
- load_data  in  32  preload word.
- err_oob  out  1  registered; last accepted access was out of range.
- err_misalign  out  1  registered; last accepted access had addr[1:0] != 0.
- rd_cnt  out  32  count of accepted reads.
- wr_cnt  out  32  count of accepted writes.

Behaviour:
- Reset (clk edge with reset=1):
  - sram_rdata = 0, err_oob = 0, err_misalign = 0, rd_cnt = 0, wr_cnt = 0.
  - Store contents are not cleared. Any in-flight request is discarded.
- Address decode:
  - off = sram_addr - BASE_ADDR (32-bit wrap).
  - in_range = (off >> 2) < 2^DEPTH_LOG2.
  - idx = off[DEPTH_LOG2+1:2]. addr[1:0] are ignored for indexing.
- Read (sram_en=1, sram_we=0):
  - Next edge: sram_rdata = store[idx] if in_range, else NOP_INST.
  - rd_cnt += 1. err_oob and err_misalign are updated from this access.
  - Fixed 1-cycle latency. Back-to-back reads every cycle are supported.
- Write (sram_en=1, sram_we!=0):
  - If in_range, the enabled bytes of store[idx] are updated at the edge. Out-of-range writes are dropped.
  - wr_cnt += 1. Error flags are updated.
  - sram_rdata holds its previous value.
- Idle (sram_en=0): sram_rdata, error flags and counters all hold. The fetch stage depends on rdata staying stable across stall cycles.
- Read-after-write to the same word on consecutive cycles returns the new data. A write and a read can never occur in the same cycle.
- Backdoor load:
  - load_ready = ~sram_en & ~reset.
  - On load_valid & load_ready: store[load_index] = load_data (full word).
  - A backdoor load leaves rdata, flags and counters unchanged.
  - If load_valid and sram_en are both high, sram wins and the load stalls.
- Counters wrap modulo 2^32.

Decomposition:
- Shared package holds:
  - NOP_INST and default BASE_ADDR constants (also used by the fetch stage reset PC).
  - SRAM request struct {en, we[3:0], addr[31:0], wdata[31:0]}.
- One natural sub-module: sram_byte_array, a DEPTH x 32 array with 4-byte write enables and a registered read port. The decode, backdoor arbitration, error flags and counters stay in inst_sram_resp.

Test Plan:
- Reset: hold reset 2 cycles, then preload idx0 = 32'h02800c0c and idx1 = 32'h0280100c; read 0x1c000000 -> rdata 0x02800c0c next cycle; read 0x1c000004 -> 0x0280100c; rd_cnt = 2.
- Stall hold: read 0x1c000000, then sram_en=0 for 3 cycles -> rdata stays 0x02800c0c each cycle; rd_cnt unchanged.
- Byte write: write 0x1c000010, we=4'b0011, wdata=0xAABBCCDD over 0x11223344 -> subsequent read returns 0x1122CCDD; wr_cnt = 1; rdata unchanged during the write cycle.
- Out of range: read 0x1bfffffc and 0x1c004000 (DEPTH_LOG2=12) -> rdata 0x03400000, err_oob = 1 both times; next in-range read clears err_oob. Read 0x1c000002 -> err_misalign = 1, data from idx0.
- Arbitration: load_valid=1 with sram_en=1 -> load_ready = 0 and store unchanged; drop sram_en -> load accepted that cycle and readable next access.
- Reset mid-stream: issue a read, assert reset on the same edge -> rdata = 0 and counters = 0; store contents survive and a subsequent read returns the preloaded value.

Source files
------------

// File: rtl/inst_sram_resp_pkg.sv
// ---------------------------------------------------------------------
// inst_sram_resp_pkg : shared constants and request type for the
//                      instruction SRAM responder and the fetch stage.
// Revision: 1.0
// ---------------------------------------------------------------------
`default_nettype none

package inst_sram_resp_pkg;

  // andi r0,r0,0 and the reset fetch target
  localparam logic [31:0] LA_NOP_INST       = 32'h0340_0000;
  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h1c00_0000;

  typedef struct packed {
    logic        en;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } sram_req_t;

endpackage

`default_nettype wire

// File: rtl/inst_sram_resp_sram_byte_array.sv
// ---------------------------------------------------------------------
// sram_byte_array : DEPTH x 32 store, per-byte write enables and a
//                   registered read port that holds when not enabled.
// Revision: 1.0
// ---------------------------------------------------------------------
`default_nettype none

module sram_byte_array #(
  parameter int DEPTH_LOG2 = 12
) (
  input  logic                  clk,
  input  logic [3:0]            we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [31:0]           wdata,
  input  logic                  re,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [31:0]           rdata
);

  logic [31:0] mem [0:(1<<DEPTH_LOG2)-1];

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (we[b]) begin
        mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

`default_nettype wire

// File: rtl/inst_sram_resp.sv
// ---------------------------------------------------------------------
// inst_sram_resp : memory-side responder for the instruction-fetch SRAM
//                  interface with backdoor preload and access counters.
// Revision: 1.0
// ---------------------------------------------------------------------
`default_nettype none

module inst_sram_resp
  import inst_sram_resp_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = DEFAULT_BASE_ADDR,
  parameter int          DEPTH_LOG2 = 12,
  parameter logic [31:0] NOP_INST   = LA_NOP_INST
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sram_en,
  input  logic [3:0]            sram_we,
  input  logic [31:0]           sram_addr,
  input  logic [31:0]           sram_wdata,
  output logic [31:0]           sram_rdata,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [DEPTH_LOG2-1:0] load_index,
  input  logic [31:0]           load_data,
  output logic                  err_oob,
  output logic                  err_misalign,
  output logic [31:0]           rd_cnt,
  output logic [31:0]           wr_cnt
);

  sram_req_t             req;
  logic [29:0]           word_off;
  logic                  in_range;
  logic [DEPTH_LOG2-1:0] idx;
  logic                  rd_acc;
  logic                  wr_acc;
  logic                  load_fire;
  logic [3:0]            arr_we;
  logic [DEPTH_LOG2-1:0] arr_waddr;
  logic [31:0]           arr_wdata;
  logic [31:0]           arr_rdata;
  logic                  rdata_zero;
  logic                  rdata_nop;

  assign req = '{en: sram_en, we: sram_we, addr: sram_addr, wdata: sram_wdata};

  // Base is word aligned, so the word offset is the difference of word addresses.
  assign word_off = req.addr[31:2] - BASE_ADDR[31:2];
  assign in_range = (word_off[29:DEPTH_LOG2] == '0);
  assign idx      = word_off[DEPTH_LOG2-1:0];

  assign rd_acc     = req.en & (req.we == 4'b0000) & ~reset;
  assign wr_acc     = req.en & (req.we != 4'b0000) & ~reset;
  assign load_ready = ~sram_en & ~reset;
  assign load_fire  = load_valid & load_ready;

  always_comb begin
    arr_we    = 4'b0000;
    arr_waddr = load_index;
    arr_wdata = load_data;
    if (wr_acc) begin
      arr_we    = in_range ? req.we : 4'b0000;
      arr_waddr = idx;
      arr_wdata = req.wdata;
    end else if (load_fire) begin
      arr_we = 4'b1111;
    end
  end

  sram_byte_array #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .waddr (arr_waddr),
    .wdata (arr_wdata),
    .re    (rd_acc & in_range),
    .raddr (idx),
    .rdata (arr_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_zero   <= 1'b1;
      rdata_nop    <= 1'b0;
      err_oob      <= 1'b0;
      err_misalign <= 1'b0;
      rd_cnt       <= '0;
      wr_cnt       <= '0;
    end else begin
      if (req.en) begin
        err_oob      <= ~in_range;
        err_misalign <= (req.addr[1:0] != 2'b00);
      end
      if (rd_acc) begin
        rdata_zero <= 1'b0;
        rdata_nop  <= ~in_range;
        rd_cnt     <= rd_cnt + 32'd1;
      end
      if (wr_acc) begin
        wr_cnt <= wr_cnt + 32'd1;
      end
    end
  end

  // Array data only moves on accepted reads, so the output holds across stalls.
  assign sram_rdata = rdata_zero ? 32'h0 : (rdata_nop ? NOP_INST : arr_rdata);

endmodule

`default_nettype wire
